uart_rx_framer: RTL and testbench

- Serial UART receiver that sits directly upstream of the udm protocol engine.
- Deserialises the board UART_TXD_IN line into bytes and emits a one-cycle rx_done_tick_o with the byte on dout_bo, which udm consumes.
- Runtime bit period and parity mode: 00 none, 10 even, 01 odd, 11 treated as none.
- Adds start-glitch rejection, parity check and framing-error detection.

---
 rtl/uart_rx_framer.sv | 158 +++++++++++++++
 tb/tb_uart_rx_framer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_framer.sv
// UART receiver feeding the udm protocol engine: 2-flop synchronised input, runtime bit period,
// optional even/odd parity, start-glitch rejection and framing-error (break) detection.
module uart_rx_framer #(
    parameter int DIV_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 rx_i,
    input  logic [DIV_WIDTH-1:0] bit_period_i,
    input  logic [1:0]           parity_cfg_i,
    output logic                 rx_done_tick_o,
    output logic [7:0]           dout_bo,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 busy_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BRK
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [DIV_WIDTH-1:0] r_cnt;
    logic [DIV_WIDTH-1:0] r_period;
    logic [DIV_WIDTH-1:0] r_half;
    logic                 r_par_en;
    logic                 r_par_odd;
    logic                 r_par_err;
    logic [7:0]           r_shift;
    logic [2:0]           r_bit_idx;

    logic                 w_rxs;
    logic [DIV_WIDTH-1:0] w_period;
    logic                 w_cnt_last;
    logic                 w_cnt_mid;

    assign w_rxs      = r_sync[1];
    assign w_period   = (bit_period_i < DIV_WIDTH'(2)) ? DIV_WIDTH'(2) : bit_period_i;
    assign w_cnt_last = (r_cnt == r_period - DIV_WIDTH'(1));
    assign w_cnt_mid  = (r_cnt == r_half - DIV_WIDTH'(1));

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], rx_i};
        end
    end

    // The cycle that sees rxs low in IDLE is t0; START then counts to floor(P/2) so every
    // later sample lands P cycles apart at the nominal bit centres.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state        <= IDLE;
            r_cnt          <= '0;
            r_period       <= DIV_WIDTH'(2);
            r_half         <= DIV_WIDTH'(1);
            r_par_en       <= 1'b0;
            r_par_odd      <= 1'b0;
            r_par_err      <= 1'b0;
            r_shift        <= 8'h00;
            r_bit_idx      <= 3'd0;
            rx_done_tick_o <= 1'b0;
            dout_bo        <= 8'h00;
            parity_err_o   <= 1'b0;
            frame_err_o    <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            rx_done_tick_o <= 1'b0;
            parity_err_o   <= 1'b0;
            frame_err_o    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!w_rxs) begin
                        r_period  <= w_period;
                        r_half    <= w_period >> 1;
                        r_par_en  <= ^parity_cfg_i;
                        r_par_odd <= (parity_cfg_i == 2'b01);
                        r_par_err <= 1'b0;
                        r_cnt     <= '0;
                        r_state   <= START;
                        busy_o    <= 1'b1;
                    end
                end
                START: begin
                    if (w_cnt_mid) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            r_state <= IDLE;
                            busy_o  <= 1'b0;
                        end else begin
                            r_state   <= DATA;
                            r_bit_idx <= 3'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end
                DATA: begin
                    if (w_cnt_last) begin
                        r_cnt     <= '0;
                        r_shift   <= {w_rxs, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= r_par_en ? PARITY : STOP;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end
                PARITY: begin
                    if (w_cnt_last) begin
                        r_cnt     <= '0;
                        r_par_err <= (^r_shift) ^ w_rxs ^ r_par_odd;
                        r_state   <= STOP;
                    end else begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end
                STOP: begin
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        if (w_rxs) begin
                            rx_done_tick_o <= 1'b1;
                            dout_bo        <= r_shift;
                            parity_err_o   <= r_par_en & r_par_err;
                            r_state        <= IDLE;
                            busy_o         <= 1'b0;
                        end else begin
                            frame_err_o <= 1'b1;
                            r_state     <= BRK;
                        end
                    end else begin
                        r_cnt <= r_cnt + DIV_WIDTH'(1);
                    end
                end
                BRK: begin
                    // A held-low line is reported once; only a return to idle re-arms the receiver.
                    if (w_rxs) begin
                        r_state <= IDLE;
                        busy_o  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed plus randomised frames against a queue-based line model for uart_rx_framer.
module tb_uart_rx_framer;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        rx_i;
    logic [15:0] bit_period_i;
    logic [1:0]  parity_cfg_i;
    logic        rx_done_tick_o;
    logic [7:0]  dout_bo;
    logic        parity_err_o;
    logic        frame_err_o;
    logic        busy_o;

    uart_rx_framer #(.DIV_WIDTH(16)) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .rx_i           (rx_i),
        .bit_period_i   (bit_period_i),
        .parity_cfg_i   (parity_cfg_i),
        .rx_done_tick_o (rx_done_tick_o),
        .dout_bo        (dout_bo),
        .parity_err_o   (parity_err_o),
        .frame_err_o    (frame_err_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [31:0] cyc;
        logic [7:0]  data;
        logic        perr;
    } tick_t;

    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          busyCycles = 0;
    int          clash = 0;
    logic [7:0]  lastByte = 8'h00;
    tick_t       gotTicks[$];
    tick_t       expTicks[$];
    logic [31:0] gotFerr[$];
    logic [31:0] expFerr[$];

    always @(posedge clk_i) cyc <= cyc + 1;

    // Outputs are observed on the falling edge, half a cycle clear of the register updates.
    always @(negedge clk_i) begin
        if (rx_done_tick_o) gotTicks.push_back({cyc, dout_bo, parity_err_o});
        if (frame_err_o) gotFerr.push_back(cyc);
        if (busy_o) busyCycles++;
        if ((parity_err_o && !rx_done_tick_o) || (frame_err_o && (rx_done_tick_o || parity_err_o)))
            clash++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic checkSegment(input string tag);
        int n;
        check({tag, "_ntick"}, gotTicks.size(), expTicks.size());
        n = (gotTicks.size() < expTicks.size()) ? gotTicks.size() : expTicks.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_tick%0d_cyc", tag, i), gotTicks[i].cyc, expTicks[i].cyc);
            check($sformatf("%s_tick%0d_data", tag, i), 32'(gotTicks[i].data), 32'(expTicks[i].data));
            check($sformatf("%s_tick%0d_perr", tag, i), 32'(gotTicks[i].perr), 32'(expTicks[i].perr));
        end
        check({tag, "_nferr"}, gotFerr.size(), expFerr.size());
        n = (gotFerr.size() < expFerr.size()) ? gotFerr.size() : expFerr.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s_ferr%0d_cyc", tag, i), gotFerr[i], expFerr[i]);
        check({tag, "_strobe_clash"}, clash, 0);
        gotTicks.delete();
        expTicks.delete();
        gotFerr.delete();
        expFerr.delete();
        clash = 0;
    endtask

    task automatic checkOutputsZero(input string tag);
        check({tag, "_tick"}, 32'(rx_done_tick_o), 0);
        check({tag, "_dout"}, 32'(dout_bo), 0);
        check({tag, "_perr"}, 32'(parity_err_o), 0);
        check({tag, "_ferr"}, 32'(frame_err_o), 0);
        check({tag, "_busy"}, 32'(busy_o), 0);
    endtask

    task automatic driveBit(input logic v, input int n);
        rx_i = v;
        repeat (n) @(negedge clk_i);
    endtask

    // Line model: bit k of the frame lasts Pe cycles; the receiver sees the line two cycles late
    // and reports the stop-bit sample one cycle after floor(Pe/2) + (9 + parity) * Pe.
    task automatic applyStimulus(input logic [7:0] data, input int p, input logic [1:0] cfg,
                                 input bit flipPar, input bit stopBit, input int lowHold,
                                 input bit scramble);
        int          pe;
        int          parEn;
        logic        parBit;
        logic [31:0] due;
        pe     = (p < 2) ? 2 : p;
        parEn  = (cfg == 2'b10 || cfg == 2'b01) ? 1 : 0;
        parBit = (cfg == 2'b01) ? ~(^data) : (^data);
        if (flipPar) parBit = ~parBit;
        bit_period_i = 16'(p);
        parity_cfg_i = cfg;
        due = cyc + 2 + (pe / 2) + (9 + parEn) * pe + 1;
        if (stopBit) begin
            expTicks.push_back({due, data, (parEn == 1) && flipPar});
            lastByte = data;
        end else begin
            expFerr.push_back(due);
        end
        driveBit(1'b0, pe);
        if (scramble) begin
            parity_cfg_i = cfg ^ 2'b11;
            bit_period_i = 16'(p + 5);
        end
        for (int i = 0; i < 8; i++) driveBit(data[i], pe);
        if (parEn == 1) driveBit(parBit, pe);
        driveBit(stopBit, pe);
        if (!stopBit) begin
            driveBit(1'b0, lowHold);
            driveBit(1'b1, 2 * pe);
        end
        rx_i = 1'b1;
    endtask

    initial begin
        rst_n_i      = 1'b0;
        rx_i         = 1'b1;
        bit_period_i = 16'd16;
        parity_cfg_i = 2'b00;
        repeat (3) @(negedge clk_i);
        checkOutputsZero("reset");
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);

        $display("[TB] plain frame");
        applyStimulus(8'hA5, 16, 2'b00, 1'b0, 1'b1, 0, 1'b0);
        repeat (48) @(negedge clk_i);
        checkSegment("plain");
        check("plain_busy_idle", 32'(busy_o), 0);
        check("plain_dout_held", 32'(dout_bo), 32'h0A5);

        $display("[TB] even parity good and bad");
        applyStimulus(8'h07, 16, 2'b10, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(8'h07, 16, 2'b10, 1'b1, 1'b1, 0, 1'b0);
        repeat (48) @(negedge clk_i);
        checkSegment("even");

        $display("[TB] odd parity with config change mid-frame");
        applyStimulus(8'h00, 16, 2'b01, 1'b0, 1'b1, 0, 1'b1);
        repeat (48) @(negedge clk_i);
        checkSegment("odd_scramble");

        $display("[TB] start glitch");
        bit_period_i = 16'd16;
        parity_cfg_i = 2'b00;
        busyCycles   = 0;
        driveBit(1'b0, 4);
        driveBit(1'b1, 64);
        checkSegment("glitch");
        check("glitch_busy_cycles", busyCycles, 8);

        $display("[TB] framing error and break");
        applyStimulus(8'h3C, 16, 2'b00, 1'b0, 1'b0, 30 * 16, 1'b0);
        repeat (16) @(negedge clk_i);
        check("break_dout_kept", 32'(dout_bo), 32'(lastByte));
        applyStimulus(8'h81, 16, 2'b00, 1'b0, 1'b1, 0, 1'b0);
        repeat (48) @(negedge clk_i);
        checkSegment("break");

        $display("[TB] back-to-back at 868 and reset mid-frame");
        applyStimulus(8'h55, 868, 2'b00, 1'b0, 1'b1, 0, 1'b0);
        applyStimulus(8'h81, 868, 2'b00, 1'b0, 1'b1, 0, 1'b0);
        driveBit(1'b0, 868);
        driveBit(1'b1, 868);
        driveBit(1'b0, 868);
        rst_n_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checkOutputsZero("midreset");
        lastByte = 8'h00;
        rx_i     = 1'b1;
        rst_n_i  = 1'b1;
        repeat (868 * 12) @(negedge clk_i);
        checkSegment("b2b");
        applyStimulus(8'h5A, 868, 2'b00, 1'b0, 1'b1, 0, 1'b0);
        repeat (868) @(negedge clk_i);
        checkSegment("after_reset");

        $display("[TB] randomised frames");
        for (int f = 0; f < 24; f++) begin
            int   p;
            bit   stopBit;
            p       = $urandom_range(0, 24);
            stopBit = ($urandom_range(0, 4) != 0);
            applyStimulus(8'($urandom), p, 2'($urandom), 1'($urandom), stopBit,
                          $urandom_range(0, 60), 1'b0);
            driveBit(1'b1, $urandom_range(0, 8));
        end
        repeat (80) @(negedge clk_i);
        checkSegment("random");
        check("random_dout_held", 32'(dout_bo), 32'(lastByte));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
